sync_r2w_ptr: RTL and testbench

//  Parametrised read-to-write pointer synchronizer for the async FIFO.
//  - Carries the gray-coded read pointer into the w_clk domain through STAGES flops.
//  - Adds a registered binary copy, a per-cycle advance count and a warm-up valid flag.
//  - Adds a sticky error flag for gray-code violations.
//  - Feeds the write-side full / free-space logic.

---
 rtl/sync_r2w_ptr_if.sv | 26 ++
 rtl/sync_r2w_ptr.sv | 110 +++++++++++
 tb/tb_sync_r2w_ptr.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sync_r2w_ptr_if.sv
// Bundle between the write-side logic and the read-pointer synchronizer.
// The master drives the raw gray pointer and error clear; the slave returns the synchronized views.
interface sync_r2w_ptr_if #(
    parameter int DEPTH = 16
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] rptr;
    logic          clr_err;
    logic [PW-1:0] wsync_gray;
    logic [PW-1:0] wsync_bin;
    logic          rd_adv;
    logic [PW-1:0] rd_adv_cnt;
    logic          sync_valid;
    logic          gray_err;

    modport master (
        output rptr, clr_err,
        input  wsync_gray, wsync_bin, rd_adv, rd_adv_cnt, sync_valid, gray_err
    );

    modport slave (
        input  rptr, clr_err,
        output wsync_gray, wsync_bin, rd_adv, rd_adv_cnt, sync_valid, gray_err
    );
endinterface

// File: rtl/sync_r2w_ptr.sv
// Brings the gray read pointer into w_clk, with binary copy, per-cycle advance count,
// warm-up valid and a sticky advisory flag for multi-bit gray steps.
module sync_r2w_ptr #(
    parameter int DEPTH     = 16,
    parameter int STAGES    = 2,
    parameter bit ERR_CHECK = 1
) (
    input  logic          w_clk,
    input  logic          rst_n,
    sync_r2w_ptr_if.slave bus
);
    localparam int         AW        = $clog2(DEPTH);
    localparam int         PW        = AW + 1;
    localparam logic [2:0] WARM_DONE = 3'(STAGES + 1);

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("sync_r2w_ptr: STAGES must be in 2..4");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_r2w_ptr: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [STAGES-1:0][PW-1:0] sync_q, sync_d;
    logic [PW-1:0]             bin_q, bin_d;
    logic [PW-1:0]             cnt_q, cnt_d;
    logic                      adv_q, adv_d;
    logic [2:0]                warm_q, warm_d;
    logic                      valid_q, valid_d;
    logic [PW-1:0]             gray_now;
    logic [PW-1:0]             bin_now;

    assign gray_now = sync_q[STAGES-1];
    assign bin_now  = gray2bin(gray_now);

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.rptr;
        for (int k = 1; k < STAGES; k++) sync_d[k] = sync_q[k-1];
        bin_d   = bin_now;
        // Modular subtraction so the 2^PW-1 -> 0 wrap still reports one entry.
        cnt_d   = bin_now - bin_q;
        adv_d   = valid_q & (cnt_d != '0);
        warm_d  = (warm_q == WARM_DONE) ? warm_q : warm_q + 3'd1;
        valid_d = (warm_d == WARM_DONE);
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            adv_q   <= 1'b0;
            warm_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            adv_q   <= adv_d;
            warm_q  <= warm_d;
            valid_q <= valid_d;
        end
    end

    generate
        if (ERR_CHECK) begin : g_err
            logic [PW-1:0] gray_q, gray_d;
            logic [PW-1:0] flip;
            logic          err_q, err_d;

            always_comb begin
                gray_d = gray_now;
                flip   = gray_now ^ gray_q;
                // x & (x-1) is nonzero exactly when more than one bit is set.
                err_d  = (valid_q & ((flip & (flip - 1'b1)) != '0)) | (err_q & ~bus.clr_err);
            end

            always_ff @(posedge w_clk or negedge rst_n) begin
                if (!rst_n) begin
                    gray_q <= '0;
                    err_q  <= 1'b0;
                end else begin
                    gray_q <= gray_d;
                    err_q  <= err_d;
                end
            end

            assign bus.gray_err = err_q;
        end else begin : g_no_err
            logic unused_clr_err;
            assign unused_clr_err = bus.clr_err;
            assign bus.gray_err   = 1'b0;
        end
    endgenerate

    assign bus.wsync_gray = gray_now;
    assign bus.wsync_bin  = bin_q;
    assign bus.rd_adv     = adv_q;
    assign bus.rd_adv_cnt = cnt_q;
    assign bus.sync_valid = valid_q;
endmodule

// File: tb/tb_sync_r2w_ptr.sv
// Directed checks of the read-pointer synchronizer: warm-up, latency, wrap, gray errors,
// mid-operation reset, across three parameter sets.
module tb_sync_r2w_ptr;
    logic w_clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 w_clk = ~w_clk;

    sync_r2w_ptr_if #(.DEPTH(16)) a_if ();
    sync_r2w_ptr_if #(.DEPTH(64)) b_if ();
    sync_r2w_ptr_if #(.DEPTH(2))  c_if ();

    sync_r2w_ptr #(.DEPTH(16), .STAGES(2), .ERR_CHECK(1)) dut_a (.w_clk(w_clk), .rst_n(rst_n), .bus(a_if));
    sync_r2w_ptr #(.DEPTH(64), .STAGES(3), .ERR_CHECK(0)) dut_b (.w_clk(w_clk), .rst_n(rst_n), .bus(b_if));
    sync_r2w_ptr #(.DEPTH(2),  .STAGES(4), .ERR_CHECK(1)) dut_c (.w_clk(w_clk), .rst_n(rst_n), .bus(c_if));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge w_clk);
        #1;
    endtask

    initial begin
        int adv_seen;
        int bad_cnt;
        int wrap_seen;
        logic [4:0] g;

        a_if.rptr = '0; a_if.clr_err = 1'b0;
        b_if.rptr = '0; b_if.clr_err = 1'b0;
        c_if.rptr = '0; c_if.clr_err = 1'b0;

        // Reset state
        tick(2);
        chk("rst_gray",  a_if.wsync_gray, 0);
        chk("rst_bin",   a_if.wsync_bin,  0);
        chk("rst_adv",   a_if.rd_adv,     0);
        chk("rst_cnt",   a_if.rd_adv_cnt, 0);
        chk("rst_valid", a_if.sync_valid, 0);
        chk("rst_err",   a_if.gray_err,   0);
        chk("rst_valid_b", b_if.sync_valid, 0);
        chk("rst_valid_c", c_if.sync_valid, 0);

        // Warm-up: valid after STAGES+1 edges from release
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk($sformatf("warm_a_%0d", k), a_if.sync_valid, (k >= 3) ? 1 : 0);
            chk($sformatf("warm_b_%0d", k), b_if.sync_valid, (k >= 4) ? 1 : 0);
            chk($sformatf("warm_c_%0d", k), c_if.sync_valid, (k >= 5) ? 1 : 0);
            chk($sformatf("warm_adv_%0d", k), a_if.rd_adv, 0);
            chk($sformatf("warm_err_%0d", k), a_if.gray_err, 0);
        end
        tick(2);

        // Latency: 0 -> 1 on all three instances
        a_if.rptr = 5'd1;
        b_if.rptr = 7'd1;
        c_if.rptr = 2'd1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk($sformatf("lat_a_gray_%0d", k), a_if.wsync_gray, (k >= 2) ? 1 : 0);
            chk($sformatf("lat_a_bin_%0d", k),  a_if.wsync_bin,  (k >= 3) ? 1 : 0);
            chk($sformatf("lat_a_adv_%0d", k),  a_if.rd_adv,     (k == 3) ? 1 : 0);
            chk($sformatf("lat_a_cnt_%0d", k),  a_if.rd_adv_cnt, (k == 3) ? 1 : 0);
            chk($sformatf("lat_b_gray_%0d", k), b_if.wsync_gray, (k >= 3) ? 1 : 0);
            chk($sformatf("lat_b_bin_%0d", k),  b_if.wsync_bin,  (k >= 4) ? 1 : 0);
            chk($sformatf("lat_b_adv_%0d", k),  b_if.rd_adv,     (k == 4) ? 1 : 0);
            chk($sformatf("lat_c_gray_%0d", k), c_if.wsync_gray, (k >= 4) ? 1 : 0);
            chk($sformatf("lat_c_bin_%0d", k),  c_if.wsync_bin,  (k >= 5) ? 1 : 0);
            chk($sformatf("lat_c_adv_%0d", k),  c_if.rd_adv,     (k == 5) ? 1 : 0);
        end

        // Wrap: step through all 32 gray codes, bin 2..31,0,1
        adv_seen = 0; bad_cnt = 0; wrap_seen = 0;
        for (int i = 0; i < 36; i++) begin
            if (i < 32) begin
                g = 5'((2 + i) % 32);
                a_if.rptr = g ^ (g >> 1);
            end
            tick(1);
            if (a_if.rd_adv) begin
                adv_seen++;
                if (a_if.rd_adv_cnt != 5'd1) bad_cnt++;
                if (a_if.wsync_bin == 5'd0 && a_if.rd_adv_cnt == 5'd1) wrap_seen = 1;
            end
        end
        chk("wrap_pulses",  adv_seen, 32);
        chk("wrap_bad_cnt", bad_cnt, 0);
        chk("wrap_31_to_0", wrap_seen, 1);
        chk("wrap_err",     a_if.gray_err, 0);
        chk("wrap_end_bin", a_if.wsync_bin, 1);

        // Gray violation 00000 -> 00011
        a_if.rptr = 5'd0;
        b_if.rptr = 7'd0;
        tick(5);
        chk("viol_pre_err", a_if.gray_err, 0);
        a_if.rptr = 5'b00011;
        b_if.rptr = 7'b0000011;
        tick(2);
        chk("viol_n2_err", a_if.gray_err, 0);
        a_if.clr_err = 1'b1;
        tick(1);
        chk("viol_set_wins", a_if.gray_err, 1);
        chk("viol_bin", a_if.wsync_bin, 2);
        a_if.clr_err = 1'b0;
        tick(1);
        chk("viol_sticky", a_if.gray_err, 1);
        a_if.clr_err = 1'b1;
        tick(1);
        chk("viol_cleared", a_if.gray_err, 0);
        a_if.clr_err = 1'b0;
        tick(1);
        chk("viol_stay_clr", a_if.gray_err, 0);
        chk("viol_noerrchk", b_if.gray_err, 0);

        // Mid-operation reset with rptr = gray 01100 (bin 8)
        a_if.rptr = 5'b01100;
        tick(4);
        chk("mid_pre_bin", a_if.wsync_bin, 8);
        rst_n = 1'b0;
        #1;
        chk("mid_gray",  a_if.wsync_gray, 0);
        chk("mid_bin",   a_if.wsync_bin,  0);
        chk("mid_adv",   a_if.rd_adv,     0);
        chk("mid_cnt",   a_if.rd_adv_cnt, 0);
        chk("mid_valid", a_if.sync_valid, 0);
        chk("mid_err",   a_if.gray_err,   0);
        @(posedge w_clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        chk("rel1_valid", a_if.sync_valid, 0);
        tick(1);
        chk("rel2_valid", a_if.sync_valid, 0);
        chk("rel2_gray",  a_if.wsync_gray, 5'b01100);
        tick(1);
        chk("rel3_valid", a_if.sync_valid, 1);
        chk("rel3_bin",   a_if.wsync_bin,  8);
        chk("rel3_cnt",   a_if.rd_adv_cnt, 8);
        chk("rel3_adv",   a_if.rd_adv,     0);
        tick(1);
        chk("rel4_adv",   a_if.rd_adv,     0);
        chk("rel4_cnt",   a_if.rd_adv_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
